// File: rtl/if_pkg.sv
// Shared fetch-stage types and constants for the in-order RISC-V pipeline.
package if_pkg;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } fetch_state_e;

    localparam logic [31:0] HALT_INSTR = 32'h0010_0073;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

endpackage

// File: rtl/if_pc_gen.sv
// Next-PC selection: redirect target, then sequential increment on fire, else hold.
module if_pc_gen #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned PC_STEP = 1
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic            fire_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic [PC_W-1:0] pc_next_o
);

    always_comb begin
        pc_next_o = pc_i;
        if (redirect_i) begin
            pc_next_o = redirect_pc_i;
        end else if (fire_i) begin
            // Truncation to PC_W bits gives the required wrap-around.
            pc_next_o = pc_i + PC_W'(PC_STEP);
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID register, valid/ready handshake and redirect.
// Define IF_HALT_EN to enable halt-on-EBREAK.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned PC_STEP  = 1,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] if_id,
    output logic               if_id_valid,
    input  logic               id_ready,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] if_id_q, if_id_d;
    logic               if_id_valid_q, if_id_valid_d;
    logic               fire;

    assign fire = (state_q == StRun) && (!if_id_valid_q || id_ready);

    if_pc_gen #(
        .PC_W    (PC_W),
        .PC_STEP (PC_STEP)
    ) u_pc_gen (
        .pc_i          (pc_q),
        .fire_i        (fire),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .pc_next_o     (pc_d)
    );

    always_comb begin
        state_d       = state_q;
        if_id_d       = if_id_q;
        if_id_valid_d = if_id_valid_q;
        if (redirect) begin
            // The instruction fetched this cycle belongs to the wrong path.
            state_d       = StRun;
            if_id_d       = INSTR_W'(NOP_INSTR);
            if_id_valid_d = 1'b0;
        end else begin
            case (state_q)
                StBoot: state_d = StRun;
                StRun: begin
                    if (fire) begin
                        if_id_d       = instruction;
                        if_id_valid_d = 1'b1;
`ifdef IF_HALT_EN
                        if (instruction == INSTR_W'(HALT_INSTR)) begin
                            state_d = StHalt;
                        end
`endif
                    end
                end
`ifdef IF_HALT_EN
                StHalt: begin
                    if (id_ready) begin
                        if_id_valid_d = 1'b0;
                    end
                end
`endif
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q       <= StBoot;
            pc_q          <= PC_W'(RESET_PC);
            if_id_q       <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_q       <= if_id_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign pc          = pc_q;
    assign if_id       = if_id_q;
    assign if_id_valid = if_id_valid_q;

`ifdef IF_HALT_EN
    assign halted = (state_q == StHalt);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Parametrised instruction-fetch stage for the in-order RISC-V pipeline: drives the instruction-memory address, captures the returned instruction into the IF/ID register, and adds a valid/ready handshake to ID, PC redirect with flush, and an optional halt-on-EBREAK mode. Instruction memory is read combinationally: `instruction` corresponds to the current `pc` in the same cycle. Sits between instruction memory and the ID stage; redirects come from EX.

## Interface

Parameters:
- PC_W, 8, PC / instruction-address width.
- INSTR_W, 32, instruction width.
- PC_STEP, 1, PC increment per fetch (1 = word-addressed memory, 4 = byte-addressed); must be < 2^PC_W.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- res_n  in  1  reset, asynchronous, active-low.
- instruction  in  INSTR_W  instruction-memory read data for the current `pc`.
- pc  out  PC_W  instruction-memory address (i_addr); registered.
- if_id  out  INSTR_W  IF/ID instruction register.
- if_id_valid  out  1  `if_id` holds an instruction ID has not yet consumed.
- id_ready  in  1  ID accepts `if_id` this cycle.
- redirect  in  1  branch/jump taken; flush and reload PC.
- redirect_pc  in  PC_W  new fetch address.
- halted  out  1  fetch halted on EBREAK (`IF_HALT_EN` only).

## Operation

- States: BOOT, RUN, HALT.
- Reset (asynchronous): `pc`=RESET_PC, `if_id`=0, `if_id_valid`=0, state=BOOT, `halted`=0.
- BOOT: lasts one cycle after reset release. No capture, `pc` held. Next state is RUN.
- RUN: fire = ~if_id_valid | id_ready.
  - When fire is high: `if_id`<=instruction, `if_id_valid`<=1, `pc`<=pc+PC_STEP, truncated to PC_W bits (wraps 2^PC_W-1 → 0 for PC_STEP=1).
  - When fire is low: `pc`, `if_id` and `if_id_valid` are held. `if_id` must stay stable while valid and not ready.
- EBREAK (`IF_HALT_EN`): on fire with instruction == HALT_INSTR (32'h0010_0073):
  - The EBREAK is captured normally and `pc` advances.
  - State goes to HALT.
- HALT:
  - No further captures; `pc` is held.
  - The pending `if_id` drains normally: `if_id_valid`<=0 when `id_ready`.
  - `halted`=1.
- Redirect: has highest priority in every state, including BOOT and HALT.
  - Updates: `pc`<=redirect_pc, `if_id_valid`<=0, `if_id`<=0, state<=RUN.
  - The instruction present that cycle is discarded, even if fire is high.
- Consumption: a transfer to ID occurs when `if_id_valid & id_ready`. A simultaneous refill in the same cycle is allowed, giving back-to-back throughput of 1 instruction/cycle.

## Timing

- Fetch latency: the instruction at address A appears on `if_id`, with `if_id_valid`=1, on the edge after `pc`==A with fire high.
- Reset release: the first capture happens on the second rising edge after `res_n` deasserts (one edge spent in BOOT).
- Redirect:
  - The target instruction is on `if_id` two edges after the `redirect` cycle: edge 1 loads `pc`, edge 2 captures.
  - Exactly one bubble (`if_id_valid`=0) is inserted.
- Stall: `id_ready` low with `if_id_valid`=1 freezes `pc` and `if_id` on the same edge; there is zero-cycle restart when `id_ready` rises.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous); no partial state survives.

## Configuration

- `IF_HALT_EN` defined:
  - EBREAK detection and the HALT state are present.
  - `halted` is driven as described in Operation.
- `IF_HALT_EN` undefined:
  - The HALT state and comparator are absent.
  - EBREAK is fetched like any other instruction.
  - `halted` is tied to 0.

## Structure

- Shared package `if_pkg`:
  - fetch-state enum (BOOT, RUN, HALT);
  - HALT_INSTR constant;
  - NOP_INSTR constant (0, the flush value), for reuse by ID/EX.
- One sub-module `if_pc_gen`: next-PC selection, in priority order redirect_pc → pc+PC_STEP on fire → hold. It is purely combinational and has PC_W/PC_STEP parameters; the state register and IF/ID register stay in the top.

## Test plan

- Reset/boot: hold `res_n`=0, then release, `id_ready`=1, memory word k = 32'h1000_0000+k.
  - Cycle after release: `pc`=0, `if_id_valid`=0.
  - Then `if_id`=32'h1000_0000, 32'h1000_0001, … consecutively, with `pc` incrementing 1,2,3.
- Stall: `id_ready`=0 for 3 cycles while `if_id`=32'h1000_0004 is valid.
  - `pc`=5 and `if_id` unchanged for all 3 cycles.
  - 32'h1000_0005 is captured on the edge after `id_ready` returns to 1.
- Redirect during stall: `redirect`=1, `redirect_pc`=8'h40, `id_ready`=0.
  - Next edge: `pc`=8'h40, `if_id_valid`=0, `if_id`=0.
  - Following edge: `if_id`=mem[8'h40], valid=1.
- Wrap: PC_STEP=4, PC_W=8, `pc`=8'hFC, fire → next `pc`=8'h00, and `if_id`=mem[8'hFC].
- Halt (`IF_HALT_EN`): place 32'h0010_0073 at address 6.
  - The EBREAK is captured and `halted`=1 on the same edge; `pc`=7 is frozen.
  - `if_id_valid` drops after ID consumes the EBREAK.
  - A later `redirect` to 0 clears `halted` and fetching resumes.
- Async reset mid-stream: pulse `res_n` low between edges while `if_id_valid`=1 → `pc`=RESET_PC, `if_id`=0, `if_id_valid`=0, `halted`=0 immediately, before the next clock edge.
